csr_access_unit: RTL and testbench
==================================

# csr_access_unit

Initiator side of the CSR register-file port: executes Zicsr operations (CSRRW/S/C and immediate forms) issued by the execute stage. It sequences a read, then a read-modify-write, onto the CSR file's `csr_rd`/`csr_wr` port. It returns the old CSR value for writeback to `rd` through a valid/ready response handshake. It sits between the execute stage and the CSR register file, one operation in flight at a time.

## Interface
- `XLEN`, default 32: data width.
- `CSR_AW`, default 12: CSR address width.

- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request from execute stage.
- `req_ready`  out  1  unit idle; request accepted when `req_valid & req_ready`.
- `funct3`  in  3  Zicsr encoding: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- `csr_addr`  in  CSR_AW  target CSR.
- `rs1_data`  in  XLEN  register source operand.
- `zimm`  in  5  immediate source, zero-extended to XLEN.
- `rs1_is_x0`  in  1  rs1 field is x0.
- `rd_is_x0`  in  1  rd field is x0.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes result.
- `rsp_data`  out  XLEN  old CSR value, 0 if no read performed.
- `rsp_illegal`  out  1  illegal operation flag.
- `csr_rd`  out  1  read strobe to CSR file.
- `rd_addr`  out  CSR_AW  read address.
- `rd_dat`  in  XLEN  combinational read data from CSR file, valid in the same cycle as `csr_rd`.
- `csr_wr`  out  1  write strobe; the CSR file writes on the next rising edge.
- `wr_addr`  out  CSR_AW  write address.
- `wr_dat`  out  XLEN  write data.

## Operation
- Request fields are latched on acceptance. Inputs are ignored at all other times.
- `src` = `funct3[2]` ? {27'b0, zimm} : `rs1_data`.
- `src_zero` = `funct3[2]` ? (zimm == 0) : `rs1_is_x0`.
- A read is needed unless the op is RW/RWI with `rd_is_x0`.
- A write is needed unless the op is RS/RC/RSI/RCI with `src_zero`.
- Write data:
  - RW: `src`.
  - RS: `old | src`.
  - RC: `old & ~src`.
  - `old` is the value latched in READ, or 0 if no read was performed.
- FSM states and transitions:
  - IDLE: `req_ready`=1. On accept: go to READ if a read is needed, else WRITE.
  - READ: `csr_rd`=1, `rd_addr`=latched address. Latch `rd_dat` into `old`. Go to WRITE if a write is needed, else RESP.
  - WRITE: `csr_wr`=1, `wr_addr`=latched address, `wr_dat` per the rule above. Go to RESP.
  - RESP: `rsp_valid`=1, `rsp_data`=`old`. Hold until `rsp_ready`, then go to IDLE.
- funct3 000/100 are invalid: no CSR access, go directly to RESP with `rsp_data`=0 and `rsp_illegal`=1.
- Outputs `csr_rd`/`csr_wr` are registered-state decodes, never both 1. Address and data outputs are 0 when their strobe is 0.

## Timing
- Reset values (reset low, asynchronous): state IDLE; `req_ready`, `rsp_valid`, `rsp_illegal`, `csr_rd`, `csr_wr` all 0; `rsp_data`, `rd_addr`, `wr_addr`, `wr_dat` all 0; `old`=0.
- `req_ready` = (state == IDLE) & `reset`.
- Latency from the accept edge T (`rsp_ready` held high):
  - Read+write: READ T+1, WRITE T+2, RESP T+3.
  - Read only or write only: RESP T+2.
  - Invalid funct3: RESP T+1.
- Throughput: the next request can be accepted in the cycle after RESP completes.
- `rsp_ready` low holds RESP and keeps `rsp_data` stable.
- If reset is asserted mid-operation, the unit aborts immediately. A write is not issued if WRITE had not yet reached a clock edge.

## Configuration
- `CSR_RO_TRAP_EN` defined:
  - A needed write to a read-only CSR (`csr_addr[11:10]` == 2'b11) skips WRITE. No `csr_wr` is issued.
  - READ still occurs. RESP carries `old` with `rsp_illegal`=1.
- `CSR_RO_TRAP_EN` undefined:
  - The write is issued regardless of address.
  - `rsp_illegal` is 1 only for invalid funct3.

## Test plan
- CSRRW, addr 0x300, `rs1_data`=0xA5A5_0000, CSR holds 0x0000_1234 → READ T+1, WRITE T+2 with `wr_dat`=0xA5A5_0000, RESP T+3 `rsp_data`=0x0000_1234.
- CSRRS, `rs1_data`=0x0000_0008, CSR 0x0000_0001 → `wr_dat`=0x0000_0009. CSRRCI, zimm=1 on that result → `wr_dat`=0x0000_0008.
- CSRRS with `rs1_is_x0`=1 → `csr_wr` never asserted, RESP T+2 with the old value. CSRRW with `rd_is_x0`=1 → `csr_rd` never asserted, `rsp_data`=0.
- `rsp_ready` held low 5 cycles in RESP → `rsp_valid`=1 and `rsp_data` stable. `req_ready`=0 until the handshake completes.
- Write to addr 0xF14:
  - With `CSR_RO_TRAP_EN`: no `csr_wr`, `rsp_illegal`=1.
  - Without it: `csr_wr` pulses, `rsp_illegal`=0.
- Reset pulled low during READ → all outputs 0 immediately, no `csr_wr` issued. After release, `req_ready`=1 and the next request completes normally.

Source files
------------

// File: rtl/csr_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : csr_access_unit
//  Purpose  : Initiator side of the CSR register-file port. Executes Zicsr
//             operations (CSRRW/S/C and immediate forms) as a read followed
//             by a read-modify-write, and returns the old CSR value through
//             a valid/ready response handshake. One operation in flight.
//  Options  : CSR_RO_TRAP_EN - when defined, a needed write to a read-only
//             CSR (top two address bits == 2'b11) is suppressed and the
//             response is flagged illegal.
//  Revision : 1.0 - initial release
// ============================================================================
module csr_access_unit #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              reset,
  // request from execute stage
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        funct3,
  input  logic [CSR_AW-1:0] csr_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [4:0]        zimm,
  input  logic              rs1_is_x0,
  input  logic              rd_is_x0,
  // response to writeback
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_illegal,
  // CSR file port
  output logic              csr_rd,
  output logic [CSR_AW-1:0] rd_addr,
  input  logic [XLEN-1:0]   rd_dat,
  output logic              csr_wr,
  output logic [CSR_AW-1:0] wr_addr,
  output logic [XLEN-1:0]   wr_dat
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // funct3[1:0] selects the operation class; funct3[2] selects immediate
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  state_t              state;
  state_t              state_nxt;

  // operation context captured at acceptance
  logic [CSR_AW-1:0]   addr_q;
  logic [XLEN-1:0]     src_q;
  logic [XLEN-1:0]     old_q;
  logic [1:0]          kind_q;
  logic                need_wr_q;
  logic                illegal_q;

  // request decode (only meaningful in the accept cycle)
  logic                accept;
  logic [1:0]          req_kind;
  logic                req_op_valid;
  logic [XLEN-1:0]     req_src;
  logic                req_src_zero;
  logic                req_need_rd;
  logic                req_need_wr;
  logic                req_ro;
  logic                req_wr_eff;
  logic                req_illegal;
  logic [XLEN-1:0]     wr_value;

  assign accept       = req_valid & req_ready;
  assign req_kind     = funct3[1:0];
  assign req_op_valid = (req_kind != 2'b00);
  assign req_src      = funct3[2] ? {{(XLEN-5){1'b0}}, zimm} : rs1_data;
  assign req_src_zero = funct3[2] ? (zimm == 5'd0) : rs1_is_x0;
  // RW with rd=x0 never observes the old value, so the read is skipped
  assign req_need_rd  = req_op_valid & ~((req_kind == OP_RW) & rd_is_x0);
  // set/clear with a zero source cannot change the CSR, so the write is skipped
  assign req_need_wr  = req_op_valid & ~((req_kind != OP_RW) & req_src_zero);

`ifdef CSR_RO_TRAP_EN
  // read-only CSRs live where the two top address bits are both set
  assign req_ro = (csr_addr[CSR_AW-1:CSR_AW-2] == 2'b11);
`else
  assign req_ro = 1'b0;
`endif

  assign req_wr_eff  = req_need_wr & ~req_ro;
  assign req_illegal = ~req_op_valid | (req_need_wr & req_ro);

  // write data derived from the latched operand and the old value
  always_comb begin
    wr_value = src_q;
    case (kind_q)
      OP_RW:   wr_value = src_q;
      OP_RS:   wr_value = old_q | src_q;
      OP_RC:   wr_value = old_q & ~src_q;
      default: wr_value = src_q;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic and state-decoded outputs
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    csr_rd      = 1'b0;
    rd_addr     = '0;
    csr_wr      = 1'b0;
    wr_addr     = '0;
    wr_dat      = '0;
    rsp_valid   = 1'b0;
    rsp_data    = '0;
    rsp_illegal = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = reset;
        if (accept) begin
          if (!req_op_valid) begin
            state_nxt = S_RESP;
          end else if (req_need_rd) begin
            state_nxt = S_READ;
          end else if (req_wr_eff) begin
            state_nxt = S_WRITE;
          end else begin
            state_nxt = S_RESP;
          end
        end
      end
      S_READ: begin
        csr_rd    = 1'b1;
        rd_addr   = addr_q;
        state_nxt = need_wr_q ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        csr_wr    = 1'b1;
        wr_addr   = addr_q;
        wr_dat    = wr_value;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid   = 1'b1;
        rsp_data    = old_q;
        rsp_illegal = illegal_q;
        if (rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // operation context: captured on accept, old value captured in READ
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q    <= '0;
      src_q     <= '0;
      old_q     <= '0;
      kind_q    <= 2'b00;
      need_wr_q <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      addr_q    <= csr_addr;
      src_q     <= req_src;
      old_q     <= '0;
      kind_q    <= req_kind;
      need_wr_q <= req_wr_eff;
      illegal_q <= req_illegal;
    end else if (state == S_READ) begin
      old_q     <= rd_dat;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_csr_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_csr_access_unit
//  Purpose  : Self-checking bench for csr_access_unit. Hosts a behavioural
//             CSR file, applies a directed vector table, a reset-abort
//             sequence and randomized operations checked against a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csr_access_unit;

  localparam int XLEN = 32;
  localparam int AW   = 12;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      funct3 = 3'b000;
  logic [AW-1:0]   csr_addr = '0;
  logic [XLEN-1:0] rs1_data = '0;
  logic [4:0]      zimm = '0;
  logic            rs1_is_x0 = 1'b0;
  logic            rd_is_x0 = 1'b0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_illegal;
  logic            csr_rd;
  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_dat;
  logic            csr_wr;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_dat;

  csr_access_unit #(.XLEN(XLEN), .CSR_AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .funct3(funct3), .csr_addr(csr_addr), .rs1_data(rs1_data), .zimm(zimm),
    .rs1_is_x0(rs1_is_x0), .rd_is_x0(rd_is_x0),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_illegal(rsp_illegal),
    .csr_rd(csr_rd), .rd_addr(rd_addr), .rd_dat(rd_dat),
    .csr_wr(csr_wr), .wr_addr(wr_addr), .wr_dat(wr_dat)
  );

  always #5 clk = ~clk;

`ifdef CSR_RO_TRAP_EN
  localparam bit RO_TRAP = 1'b1;
`else
  localparam bit RO_TRAP = 1'b0;
`endif

  // behavioural CSR file
  logic [XLEN-1:0] mem [0:4095];
  logic            clr_req = 1'b0;
  logic            pre_req = 1'b0;
  logic [AW-1:0]   pre_addr = '0;
  logic [XLEN-1:0] pre_val = '0;
  int              wr_total = 0;

  assign rd_dat = mem[rd_addr];

  always @(posedge clk) begin
    if (clr_req) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else begin
      if (csr_wr)  mem[wr_addr]  <= wr_dat;
      if (pre_req) mem[pre_addr] <= pre_val;
    end
  end

  always @(negedge clk) if (csr_wr) wr_total <= wr_total + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [XLEN-1:0] v);
    pre_addr = a;
    pre_val  = v;
    pre_req  = 1'b1;
    @(posedge clk); #1;
    pre_req  = 1'b0;
  endtask

  // Issues one request and observes it through to the response handshake.
  task automatic run_op(
    input  logic [2:0]      f3, input logic [AW-1:0] a, input logic [XLEN-1:0] r1,
    input  logic [4:0]      z,  input bit r1x0, input bit rdx0, input int stall,
    output logic [XLEN-1:0] o_rsp, output bit o_ill, output int o_rd, output int o_wr,
    output logic [XLEN-1:0] o_wdat, output logic [AW-1:0] o_waddr,
    output int o_lat, output int o_both, output bit o_stable);
    int guard;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("req_ready_before_op", {31'b0, req_ready}, 32'd1);
    funct3 = f3; csr_addr = a; rs1_data = r1; zimm = z;
    rs1_is_x0 = r1x0; rd_is_x0 = rdx0;
    req_valid = 1'b1;
    rsp_ready = (stall == 0);
    @(posedge clk); #1;
    // scramble request fields: the unit must ignore them after acceptance
    req_valid = 1'b0;
    funct3 = 3'($urandom); csr_addr = AW'($urandom); rs1_data = $urandom;
    zimm = 5'($urandom); rs1_is_x0 = 1'($urandom); rd_is_x0 = 1'($urandom);
    o_rd = 0; o_wr = 0; o_both = 0; o_lat = 0; o_wdat = '0; o_waddr = '0;
    forever begin
      o_lat++;
      if (csr_rd) o_rd++;
      if (csr_wr) begin o_wr++; o_wdat = wr_dat; o_waddr = wr_addr; end
      if (csr_rd && csr_wr) o_both++;
      if (rsp_valid || o_lat >= 10) break;
      @(posedge clk); #1;
    end
    o_rsp = rsp_data;
    o_ill = rsp_illegal;
    o_stable = 1'b1;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      if (!(rsp_valid && rsp_data == o_rsp && !req_ready)) o_stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [2:0]      f3;
    logic [AW-1:0]   a;
    logic [XLEN-1:0] r1;
    logic [4:0]      z;
    bit              r1x0;
    bit              rdx0;
    bit              pre_en;
    logic [XLEN-1:0] pre;
    int              stall;
    logic [XLEN-1:0] e_rsp;
    bit              e_ill;
    int              e_rd;
    int              e_wr;
    logic [XLEN-1:0] e_wdat;
    int              e_lat;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    input logic [2:0] f3, input logic [AW-1:0] a, input logic [XLEN-1:0] r1,
    input logic [4:0] z, input bit r1x0, input bit rdx0, input bit pre_en,
    input logic [XLEN-1:0] pre, input int stall, input logic [XLEN-1:0] e_rsp,
    input bit e_ill, input int e_rd, input int e_wr, input logic [XLEN-1:0] e_wdat,
    input int e_lat);
    vec_t v;
    v.f3 = f3; v.a = a; v.r1 = r1; v.z = z; v.r1x0 = r1x0; v.rdx0 = rdx0;
    v.pre_en = pre_en; v.pre = pre; v.stall = stall; v.e_rsp = e_rsp;
    v.e_ill = e_ill; v.e_rd = e_rd; v.e_wr = e_wr; v.e_wdat = e_wdat; v.e_lat = e_lat;
    return v;
  endfunction

  logic [XLEN-1:0] o_rsp, o_wdat;
  logic [AW-1:0]   o_waddr;
  bit              o_ill, o_stable;
  int              o_rd, o_wr, o_lat, o_both;

  initial begin
    int w0;
    // -------- reset state --------
    clr_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_strobes",   {30'b0, csr_rd, csr_wr}, 32'd0);
    chk("rst_rsp_data",  rsp_data, 32'd0);
    chk("rst_wr_dat",    wr_dat, 32'd0);
    clr_req = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

    // -------- directed vector table --------
    //          f3     addr    rs1           z     r1x0 rdx0 pre  preval        st  e_rsp         ill rd wr wdat          lat
    vt.push_back(mk(3'b001, 12'h300, 32'hA5A5_0000, 5'd0, 0, 0, 1, 32'h0000_1234, 0, 32'h0000_1234, 0, 1, 1, 32'hA5A5_0000, 3));
    vt.push_back(mk(3'b010, 12'h340, 32'h0000_0008, 5'd0, 0, 0, 1, 32'h0000_0001, 0, 32'h0000_0001, 0, 1, 1, 32'h0000_0009, 3));
    vt.push_back(mk(3'b111, 12'h340, 32'hFFFF_FFFF, 5'd1, 0, 0, 0, 32'h0,         0, 32'h0000_0009, 0, 1, 1, 32'h0000_0008, 3));
    vt.push_back(mk(3'b010, 12'h341, 32'h0000_FFFF, 5'd0, 1, 0, 1, 32'h0000_0055, 0, 32'h0000_0055, 0, 1, 0, 32'h0,         2));
    vt.push_back(mk(3'b001, 12'h342, 32'hDEAD_BEEF, 5'd0, 0, 1, 1, 32'h0000_0077, 0, 32'h0,         0, 0, 1, 32'hDEAD_BEEF, 2));
    vt.push_back(mk(3'b000, 12'h300, 32'h1,         5'd3, 0, 0, 0, 32'h0,         0, 32'h0,         1, 0, 0, 32'h0,         1));
    vt.push_back(mk(3'b100, 12'h300, 32'h1,         5'd3, 0, 0, 0, 32'h0,         0, 32'h0,         1, 0, 0, 32'h0,         1));
    vt.push_back(mk(3'b110, 12'h343, 32'h1234_5678, 5'd0, 0, 0, 1, 32'h0000_01F0, 0, 32'h0000_01F0, 0, 1, 0, 32'h0,         2));
    vt.push_back(mk(3'b101, 12'h344, 32'h0,         5'h15,1, 0, 1, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 0, 1, 1, 32'h0000_0015, 3));
    vt.push_back(mk(3'b011, 12'h345, 32'h0000_0F0F, 5'd0, 0, 0, 1, 32'h0000_FFFF, 5, 32'h0000_FFFF, 0, 1, 1, 32'h0000_F0F0, 3));
    if (RO_TRAP) begin
      vt.push_back(mk(3'b001, 12'hF14, 32'h0000_0123, 5'd0, 0, 0, 1, 32'h0000_0ABC, 0, 32'h0000_0ABC, 1, 1, 0, 32'h0,   2));
      vt.push_back(mk(3'b001, 12'hF15, 32'h0000_0005, 5'd0, 0, 1, 1, 32'h0000_0009, 0, 32'h0,         1, 0, 0, 32'h0,   1));
    end else begin
      vt.push_back(mk(3'b001, 12'hF14, 32'h0000_0123, 5'd0, 0, 0, 1, 32'h0000_0ABC, 0, 32'h0000_0ABC, 0, 1, 1, 32'h123, 3));
      vt.push_back(mk(3'b001, 12'hF15, 32'h0000_0005, 5'd0, 0, 1, 1, 32'h0000_0009, 0, 32'h0,         0, 0, 1, 32'h5,   2));
    end

    foreach (vt[i]) begin
      if (vt[i].pre_en) preload(vt[i].a, vt[i].pre);
      run_op(vt[i].f3, vt[i].a, vt[i].r1, vt[i].z, vt[i].r1x0, vt[i].rdx0, vt[i].stall,
             o_rsp, o_ill, o_rd, o_wr, o_wdat, o_waddr, o_lat, o_both, o_stable);
      chk($sformatf("v%0d_rsp_data", i), o_rsp, vt[i].e_rsp);
      chk($sformatf("v%0d_illegal", i), {31'b0, o_ill}, {31'b0, vt[i].e_ill});
      chk($sformatf("v%0d_rd_cycles", i), o_rd, vt[i].e_rd);
      chk($sformatf("v%0d_wr_cycles", i), o_wr, vt[i].e_wr);
      chk($sformatf("v%0d_latency", i), o_lat, vt[i].e_lat);
      chk($sformatf("v%0d_rd_wr_overlap", i), o_both, 0);
      chk($sformatf("v%0d_idle_after", i), {31'b0, req_ready}, 32'd1);
      if (vt[i].e_wr != 0) begin
        chk($sformatf("v%0d_wr_dat", i), o_wdat, vt[i].e_wdat);
        chk($sformatf("v%0d_wr_addr", i), {20'b0, o_waddr}, {20'b0, vt[i].a});
      end
      if (vt[i].stall != 0) chk($sformatf("v%0d_stall_stable", i), {31'b0, o_stable}, 32'd1);
    end

    // -------- reset asserted during READ --------
    preload(12'h300, 32'h0000_0011);
    funct3 = 3'b010; csr_addr = 12'h300; rs1_data = 32'h2; rs1_is_x0 = 1'b0; rd_is_x0 = 1'b0;
    req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_in_read", {31'b0, csr_rd}, 32'd1);
    w0 = wr_total;
    #1 reset = 1'b0;
    #1;
    chk("abort_csr_rd",    {31'b0, csr_rd}, 32'd0);
    chk("abort_rd_addr",   {20'b0, rd_addr}, 32'd0);
    chk("abort_req_ready", {31'b0, req_ready}, 32'd0);
    chk("abort_rsp",       {30'b0, rsp_valid, rsp_illegal}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_csr_wr", {31'b0, csr_wr}, 32'd0);
    @(negedge clk) reset = 1'b1;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    chk("abort_release_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_no_write", wr_total - w0, 32'd0);
    chk("abort_mem_kept", mem[12'h300], 32'h0000_0011);
    run_op(3'b010, 12'h300, 32'h2, 5'd0, 1'b0, 1'b0, 0,
           o_rsp, o_ill, o_rd, o_wr, o_wdat, o_waddr, o_lat, o_both, o_stable);
    chk("after_abort_rsp", o_rsp, 32'h0000_0011);
    chk("after_abort_wdat", o_wdat, 32'h0000_0013);
    chk("after_abort_lat", o_lat, 3);

    // -------- randomized operations vs. transaction model --------
    for (int n = 0; n < 200; n++) begin
      logic [AW-1:0]   a;
      logic [2:0]      f3;
      logic [XLEN-1:0] r1, src, old_v, cur, new_v, exp_mem;
      logic [4:0]      z;
      bit              r1x0, rdx0, op_ok, szero, need_rd, need_wr, is_ro, do_wr, ill;
      int              stall, lat;
      case ($urandom_range(0, 5))
        0: a = 12'h300;
        1: a = 12'h305;
        2: a = 12'h340;
        3: a = 12'hC00;
        4: a = 12'hF11;
        default: a = 12'h7C0;
      endcase
      if ($urandom_range(0, 3) == 0) preload(a, $urandom);
      f3    = 3'($urandom_range(0, 7));
      r1    = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      z     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      r1x0  = ($urandom_range(0, 3) == 0);
      rdx0  = ($urandom_range(0, 3) == 0);
      stall = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      cur   = mem[a];

      op_ok   = (f3[1:0] != 2'b00);
      src     = f3[2] ? {27'b0, z} : r1;
      szero   = f3[2] ? (z == 5'd0) : r1x0;
      need_rd = op_ok && !(f3[1:0] == 2'b01 && rdx0);
      need_wr = op_ok && !(f3[1:0] != 2'b01 && szero);
      is_ro   = RO_TRAP && (a >= 12'hC00);
      do_wr   = need_wr && !is_ro;
      ill     = !op_ok || (need_wr && is_ro);
      old_v   = need_rd ? cur : 32'h0;
      case (f3[1:0])
        2'b01:   new_v = src;
        2'b10:   new_v = old_v | src;
        default: new_v = old_v & ~src;
      endcase
      exp_mem = do_wr ? new_v : cur;
      lat     = 1 + (need_rd ? 1 : 0) + (do_wr ? 1 : 0);

      run_op(f3, a, r1, z, r1x0, rdx0, stall,
             o_rsp, o_ill, o_rd, o_wr, o_wdat, o_waddr, o_lat, o_both, o_stable);
      chk($sformatf("r%0d_rsp_data", n), o_rsp, old_v);
      chk($sformatf("r%0d_illegal", n), {31'b0, o_ill}, {31'b0, ill});
      chk($sformatf("r%0d_latency", n), o_lat, lat);
      chk($sformatf("r%0d_rd_cycles", n), o_rd, need_rd ? 1 : 0);
      chk($sformatf("r%0d_wr_cycles", n), o_wr, do_wr ? 1 : 0);
      chk($sformatf("r%0d_csr_value", n), mem[a], exp_mem);
      chk($sformatf("r%0d_stall_stable", n), {31'b0, o_stable}, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
